// File: rtl/nfc_sfr_pkg.sv
// Shared constants for the NFC special-function-register bank: register offsets,
// interrupt bit positions, reset values and a width helper.
package nfc_sfr_pkg;

  localparam logic [5:0] OFF_CMD       = 6'h00;
  localparam logic [5:0] OFF_FIFO_STAT = 6'h01;
  localparam logic [5:0] OFF_CE        = 6'h02;
  localparam logic [5:0] OFF_MODE      = 6'h03;
  localparam logic [5:0] OFF_TIMING    = 6'h04;
  localparam logic [5:0] OFF_INT_STAT  = 6'h05;
  localparam logic [5:0] OFF_INT_EN    = 6'h06;
  localparam logic [5:0] OFF_RNB       = 6'h07;

  localparam int INT_DONE     = 0;
  localparam int INT_ERR      = 1;
  localparam int INT_OVF      = 2;
  localparam int INT_RNB_RISE = 3;

  localparam logic [7:0] CE_RST     = 8'hFF;
  localparam logic [7:0] TIMING_RST = 8'h00;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nfc_cmd_fifo.sv
// Command byte FIFO: circular buffer with one extra pointer bit so full and empty
// are distinguishable; push while full is accepted only if a pop frees the slot.
module nfc_cmd_fifo import nfc_sfr_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic                    full,
  output logic                    empty,
  output logic [clog2(DEPTH):0]   level
);
  localparam int AW = clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop, do_push;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Storage is unreset, so mask the head while empty to keep dout clean out of reset.
  assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nfc_sfr_bank.sv
// Byte-wide SFR bank for the NFC core. Optional MODE[7] FIFO flush is built
// only when NFC_SFR_CMD_FLUSH_EN is defined.
module nfc_sfr_bank import nfc_sfr_pkg::*; #(
  parameter int ADDR_W      = 9,
  parameter int CH_NUM      = 4,
  parameter int CMD_DEPTH   = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reg_wr,
  input  logic              reg_rd,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [7:0]        reg_din,
  output logic [7:0]        reg_dout,
  input  logic [CH_NUM-1:0] rnb_i,
  output logic [7:0]        cmd_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  input  logic              done_i,
  input  logic              err_i,
  output logic [CH_NUM-1:0] nf_ceb,
  output logic [1:0]        nf_mode,
  output logic              nf_ecc_en,
  output logic              nf_edo_en,
  output logic [2:0]        nf_total_cycle,
  output logic [3:0]        nf_high_cycle,
  output logic [31:0]       nf_row_addr,
  output logic [31:0]       nf_rand_seed,
  output logic              int_o
);
  logic [5:0]        off;
  logic              wr_hit, flush, cmd_push, ovf, rise;
  logic              fifo_full, fifo_empty;
  logic [clog2(CMD_DEPTH):0] fifo_level;
  logic [3:0]        lvl4, int_stat, int_en, hw_set, w1c;
  logic [CH_NUM-1:0] ce, hist, rnb_s;
  logic [CH_NUM-1:0] sync [SYNC_STAGES];
  logic [1:0]        mode;
  logic              ecc_en;
  logic [7:0]        timing, rd_data;
  logic [31:0]       row, seed;

  assign off      = reg_addr[5:0];
  assign wr_hit   = reg_wr && ((reg_addr >> 6) == '0);
  assign cmd_push = wr_hit && (off == OFF_CMD);
`ifdef NFC_SFR_CMD_FLUSH_EN
  assign flush    = wr_hit && (off == OFF_MODE) && reg_din[7];
`else
  assign flush    = 1'b0;
`endif
  // A pop in the same cycle frees the slot, so only a true drop raises OVF.
  assign ovf      = cmd_push && fifo_full && !(cmd_valid && cmd_ready) && !flush;

  nfc_cmd_fifo #(.DEPTH(CMD_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(cmd_push), .pop(cmd_ready), .flush(flush),
    .din(reg_din), .dout(cmd_data), .full(fifo_full), .empty(fifo_empty),
    .level(fifo_level)
  );
  assign cmd_valid = !fifo_empty;
  assign lvl4      = 4'(fifo_level);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync[i] <= '0;
      hist <= '0;
    end else begin
      sync[0] <= rnb_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
      hist <= sync[SYNC_STAGES-1];
    end
  end
  assign rnb_s = sync[SYNC_STAGES-1];
  assign rise  = |(rnb_s & ~hist & ~ce);

  assign hw_set = {rise, ovf, err_i, done_i};
  assign w1c    = (wr_hit && off == OFF_INT_STAT) ? reg_din[3:0] : 4'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) int_stat <= '0;
    else        int_stat <= (int_stat & ~w1c) | hw_set;
  end
  assign int_o = |(int_stat & int_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce     <= CE_RST[CH_NUM-1:0];
      mode   <= '0;
      ecc_en <= 1'b0;
      timing <= TIMING_RST;
      int_en <= '0;
      row    <= '0;
      seed   <= '0;
    end else if (wr_hit) begin
      case (off)
        OFF_CE:     ce <= reg_din[CH_NUM-1:0];
        OFF_MODE:   begin mode <= reg_din[5:4]; ecc_en <= reg_din[0]; end
        OFF_TIMING: timing <= reg_din;
        OFF_INT_EN: int_en <= reg_din[3:0];
        default: begin
          if (off[5:3] == 3'b001) begin
            if (off[2]) seed[{off[1:0], 3'b000} +: 8] <= reg_din;
            else        row[{off[1:0], 3'b000} +: 8]  <= reg_din;
          end
        end
      endcase
    end
  end

  always_comb begin
    rd_data = 8'h00;
    if ((reg_addr >> 6) == '0) begin
      case (off)
        OFF_FIFO_STAT: rd_data = {lvl4, 2'b00, fifo_full, fifo_empty};
        OFF_CE:        rd_data = 8'(ce);
        OFF_MODE:      rd_data = {2'b00, mode, 3'b000, ecc_en};
        OFF_TIMING:    rd_data = timing;
        OFF_INT_STAT:  rd_data = {4'h0, int_stat};
        OFF_INT_EN:    rd_data = {4'h0, int_en};
        OFF_RNB:       rd_data = 8'(rnb_s);
        default: begin
          if (off[5:3] == 3'b001)
            rd_data = off[2] ? seed[{off[1:0], 3'b000} +: 8] : row[{off[1:0], 3'b000} +: 8];
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      reg_dout <= 8'h00;
    else if (reg_rd) reg_dout <= rd_data;
  end

  assign nf_ceb         = ce;
  assign nf_mode        = mode;
  assign nf_ecc_en      = ecc_en;
  assign nf_edo_en      = timing[7];
  assign nf_total_cycle = timing[6:4];
  assign nf_high_cycle  = timing[3:0];
  assign nf_row_addr    = row;
  assign nf_rand_seed   = seed;

endmodule

// File: tb/tb_nfc_sfr_bank.sv
// Directed scenarios plus a randomized run checked against a queue/array model.
module tb_nfc_sfr_bank;
  localparam int ADDR_W = 9, CH_NUM = 4, CMD_DEPTH = 4, SYNC_STAGES = 2;

  logic clk = 1'b0, rst_n = 1'b0;
  logic reg_wr = 1'b0, reg_rd = 1'b0, cmd_ready = 1'b0, done_i = 1'b0, err_i = 1'b0;
  logic [ADDR_W-1:0] reg_addr = '0;
  logic [7:0] reg_din = '0, reg_dout, cmd_data;
  logic [CH_NUM-1:0] rnb_i = '0, nf_ceb;
  logic cmd_valid, nf_ecc_en, nf_edo_en, int_o;
  logic [1:0] nf_mode;
  logic [2:0] nf_total_cycle;
  logic [3:0] nf_high_cycle;
  logic [31:0] nf_row_addr, nf_rand_seed;

  int checks = 0, failures = 0;
  logic [7:0] got_q[$];
  logic [7:0] rdv;

  // reference model state
  logic [7:0] q[$];
  logic [7:0] m_ce, m_mode, m_timing, exp_dout;
  logic [3:0] m_int, m_inten;
  logic [7:0] m_row[4], m_seed[4];

  nfc_sfr_bank #(.ADDR_W(ADDR_W), .CH_NUM(CH_NUM), .CMD_DEPTH(CMD_DEPTH), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .reg_wr(reg_wr), .reg_rd(reg_rd), .reg_addr(reg_addr),
    .reg_din(reg_din), .reg_dout(reg_dout), .rnb_i(rnb_i), .cmd_data(cmd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .done_i(done_i), .err_i(err_i),
    .nf_ceb(nf_ceb), .nf_mode(nf_mode), .nf_ecc_en(nf_ecc_en), .nf_edo_en(nf_edo_en),
    .nf_total_cycle(nf_total_cycle), .nf_high_cycle(nf_high_cycle),
    .nf_row_addr(nf_row_addr), .nf_rand_seed(nf_rand_seed), .int_o(int_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    reg_wr = 1'b1; reg_addr = a; reg_din = d;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, output logic [7:0] d);
    reg_rd = 1'b1; reg_addr = a;
    tick();
    reg_rd = 1'b0;
    d = reg_dout;
  endtask

  task automatic drain();
    got_q.delete();
    cmd_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (cmd_valid) got_q.push_back(cmd_data);
      else if (got_q.size() > 0) break;
      tick();
    end
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b0; #23;
    checks++; if (nf_ceb !== 4'hF) begin failures++; $display("FAIL reset_ceb got=%h exp=%h", nf_ceb, 4'hF); end
    checks++; if ({cmd_valid, int_o, reg_dout} !== 10'h0) begin failures++; $display("FAIL reset_outs got=%b/%b/%h exp=0", cmd_valid, int_o, reg_dout); end
    checks++; if ({nf_row_addr, nf_rand_seed, cmd_data} !== '0) begin failures++; $display("FAIL reset_data got=%h/%h/%h exp=0", nf_row_addr, nf_rand_seed, cmd_data); end
    @(posedge clk); #1; rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd(ADDR_W'(i), rdv);
      e = (i == 1) ? 8'h01 : (i == 2) ? 8'h0F : 8'h00;
      checks++; if (rdv !== e) begin failures++; $display("FAIL reset_read off=%0h got=%h exp=%h", i, rdv, e); end
    end
  endtask

  task automatic test_fifo_ovf();
    logic [7:0] cmds[5];
    cmds = '{8'h60, 8'h00, 8'h30, 8'hD0, 8'h70};
    for (int i = 0; i < 5; i++) wr(9'h000, cmds[i]);
    rd(9'h001, rdv);
    checks++; if (rdv !== 8'h42) begin failures++; $display("FAIL ovf_fifo_stat got=%h exp=%h", rdv, 8'h42); end
    rd(9'h005, rdv);
    checks++; if (rdv !== 8'h04) begin failures++; $display("FAIL ovf_int_stat got=%h exp=%h", rdv, 8'h04); end
    wr(9'h006, 8'h04);
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL ovf_int_o got=%b exp=1", int_o); end
    drain();
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL ovf_drain_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== cmds[i]) begin failures++; $display("FAIL ovf_drain_byte%0d got=%h exp=%h", i, got_q[i], cmds[i]); end
    end
    wr(9'h005, 8'h04);
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL ovf_w1c_int_o got=%b exp=0", int_o); end
    wr(9'h006, 8'h00);
  endtask

  task automatic test_full_pushpop();
    logic [7:0] exp[4];
    exp = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
    wr(9'h000, 8'hA1); wr(9'h000, 8'hA2); wr(9'h000, 8'hA3); wr(9'h000, 8'hA4);
    reg_wr = 1'b1; reg_addr = 9'h000; reg_din = 8'hB5; cmd_ready = 1'b1;
    tick();
    reg_wr = 1'b0; cmd_ready = 1'b0;
    rd(9'h001, rdv);
    checks++; if (rdv !== 8'h42) begin failures++; $display("FAIL pp_fifo_stat got=%h exp=%h", rdv, 8'h42); end
    rd(9'h005, rdv);
    checks++; if (rdv !== 8'h00) begin failures++; $display("FAIL pp_no_ovf got=%h exp=%h", rdv, 8'h00); end
    drain();
    checks++; if (got_q.size() != 4) begin failures++; $display("FAIL pp_drain_count got=%0d exp=4", got_q.size()); end
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp[i]) begin failures++; $display("FAIL pp_drain_byte%0d got=%h exp=%h", i, got_q[i], exp[i]); end
    end
  endtask

  task automatic test_rnb();
    wr(9'h002, 8'h0E);
    wr(9'h006, 8'h08);
    rnb_i[1] = 1'b1;
    repeat (6) tick();
    rd(9'h005, rdv);
    checks++; if (rdv !== 8'h00) begin failures++; $display("FAIL rnb_masked got=%h exp=%h", rdv, 8'h00); end
    rd(9'h007, rdv);
    checks++; if (rdv !== 8'h02) begin failures++; $display("FAIL rnb_read got=%h exp=%h", rdv, 8'h02); end
    rnb_i[0] = 1'b1;
    repeat (SYNC_STAGES) tick();
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL rnb_early got=%b exp=0", int_o); end
    tick();
    checks++; if (int_o !== 1'b1) begin failures++; $display("FAIL rnb_rise got=%b exp=1", int_o); end
    wr(9'h005, 8'h08);
    checks++; if (int_o !== 1'b0) begin failures++; $display("FAIL rnb_w1c got=%b exp=0", int_o); end
    done_i = 1'b1; tick(); done_i = 1'b0;
    reg_wr = 1'b1; reg_addr = 9'h005; reg_din = 8'h01; done_i = 1'b1;
    tick();
    reg_wr = 1'b0; done_i = 1'b0;
    rd(9'h005, rdv);
    checks++; if (rdv !== 8'h01) begin failures++; $display("FAIL done_set_wins got=%h exp=%h", rdv, 8'h01); end
    err_i = 1'b1; tick(); err_i = 1'b0;
    rd(9'h005, rdv);
    checks++; if (rdv !== 8'h03) begin failures++; $display("FAIL err_sticky got=%h exp=%h", rdv, 8'h03); end
    wr(9'h005, 8'h0F);
    rd(9'h005, rdv);
    checks++; if (rdv !== 8'h00) begin failures++; $display("FAIL int_clear got=%h exp=%h", rdv, 8'h00); end
    rnb_i = '0;
    wr(9'h006, 8'h00);
    wr(9'h002, 8'h0F);
  endtask

  task automatic test_row_seed();
    wr(9'h008, 8'h11); wr(9'h009, 8'h22); wr(9'h00A, 8'h33); wr(9'h00B, 8'h44);
    checks++; if (nf_row_addr !== 32'h44332211) begin failures++; $display("FAIL row_addr got=%h exp=%h", nf_row_addr, 32'h44332211); end
    wr(9'h108, 8'hFF);
    checks++; if (nf_row_addr !== 32'h44332211) begin failures++; $display("FAIL upper_addr_write got=%h exp=%h", nf_row_addr, 32'h44332211); end
    wr(9'h00C, 8'hEF); wr(9'h00D, 8'hBE); wr(9'h00E, 8'hAD); wr(9'h00F, 8'hA5);
    checks++; if (nf_rand_seed !== 32'hA5ADBEEF) begin failures++; $display("FAIL seed got=%h exp=%h", nf_rand_seed, 32'hA5ADBEEF); end
    rd(9'h00F, rdv);
    checks++; if (rdv !== 8'hA5) begin failures++; $display("FAIL seed3_read got=%h exp=%h", rdv, 8'hA5); end
    repeat (3) tick();
    checks++; if (reg_dout !== 8'hA5) begin failures++; $display("FAIL dout_hold got=%h exp=%h", reg_dout, 8'hA5); end
    rd(9'h108, rdv);
    checks++; if (rdv !== 8'h00) begin failures++; $display("FAIL upper_addr_read got=%h exp=%h", rdv, 8'h00); end
    rd(9'h01C, rdv);
    checks++; if (rdv !== 8'h00) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", rdv, 8'h00); end
  endtask

`ifdef NFC_SFR_CMD_FLUSH_EN
  task automatic test_flush();
    wr(9'h000, 8'h01); wr(9'h000, 8'h02); wr(9'h000, 8'h03);
    wr(9'h003, 8'h80);
    checks++; if (cmd_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", cmd_valid); end
    rd(9'h001, rdv);
    checks++; if (rdv !== 8'h01) begin failures++; $display("FAIL flush_fifo_stat got=%h exp=%h", rdv, 8'h01); end
    rd(9'h003, rdv);
    checks++; if (rdv !== 8'h00) begin failures++; $display("FAIL flush_mode_read got=%h exp=%h", rdv, 8'h00); end
  endtask
`endif

  function automatic logic [7:0] mread(input logic [ADDR_W-1:0] a);
    logic [7:0] lv;
    int sz;
    sz = q.size();
    lv = 8'(sz);
    if (a[ADDR_W-1:6] != '0) return 8'h00;
    case (a[5:0])
      6'h01: return {lv[3:0], 2'b00, sz == CMD_DEPTH, sz == 0};
      6'h02: return m_ce;
      6'h03: return m_mode;
      6'h04: return m_timing;
      6'h05: return {4'h0, m_int};
      6'h06: return {4'h0, m_inten};
      6'h08, 6'h09, 6'h0A, 6'h0B: return m_row[a[1:0]];
      6'h0C, 6'h0D, 6'h0E, 6'h0F: return m_seed[a[1:0]];
      default: return 8'h00;
    endcase
  endfunction

  task automatic test_random();
    logic w, r, rdy, pop, ovf, fl, mapped;
    logic [ADDR_W-1:0] a;
    logic [7:0] d;
    logic [5:0] o;
    logic [3:0] hs;
    int sz;
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    q.delete();
    m_ce = 8'h0F; m_mode = 0; m_timing = 0; m_int = 0; m_inten = 0; exp_dout = 0;
    for (int i = 0; i < 4; i++) begin m_row[i] = 0; m_seed[i] = 0; end
    for (int cyc = 0; cyc < 400; cyc++) begin
      w = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 2) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) a = '0;
      else if ($urandom_range(0, 9) < 8) a = ADDR_W'($urandom_range(0, 15));
      else a = ADDR_W'($urandom_range(0, 511));
      d = 8'($urandom);
      reg_wr = w; reg_rd = r; reg_addr = a; reg_din = d; cmd_ready = rdy;
      done_i = ($urandom_range(0, 7) == 0);
      err_i = ($urandom_range(0, 7) == 0);
      // model the coming edge
      if (r) exp_dout = mread(a);
      mapped = (a[ADDR_W-1:6] == '0);
      o = a[5:0];
      sz = q.size();
      pop = rdy && sz > 0;
      fl = 1'b0;
`ifdef NFC_SFR_CMD_FLUSH_EN
      fl = w && mapped && o == 6'h03 && d[7];
`endif
      ovf = 1'b0;
      if (fl) q.delete();
      else begin
        if (pop) void'(q.pop_front());
        if (w && mapped && o == 6'h00) begin
          if (sz < CMD_DEPTH || pop) q.push_back(d);
          else ovf = 1'b1;
        end
      end
      hs = {1'b0, ovf, err_i, done_i};
      if (w && mapped && o == 6'h05) m_int = m_int & ~d[3:0];
      m_int = m_int | hs;
      if (w && mapped) begin
        case (o)
          6'h02: m_ce = d & 8'h0F;
          6'h03: m_mode = d & 8'h31;
          6'h04: m_timing = d;
          6'h06: m_inten = d[3:0];
          6'h08, 6'h09, 6'h0A, 6'h0B: m_row[o[1:0]] = d;
          6'h0C, 6'h0D, 6'h0E, 6'h0F: m_seed[o[1:0]] = d;
          default: ;
        endcase
      end
      tick();
      checks++; if (reg_dout !== exp_dout) begin failures++; $display("FAIL rand_dout cyc=%0d got=%h exp=%h", cyc, reg_dout, exp_dout); end
      checks++; if (cmd_valid !== (q.size() > 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", cyc, cmd_valid, q.size() > 0); end
      if (q.size() > 0) begin
        checks++; if (cmd_data !== q[0]) begin failures++; $display("FAIL rand_head cyc=%0d got=%h exp=%h", cyc, cmd_data, q[0]); end
      end
      checks++; if (int_o !== |(m_int & m_inten)) begin failures++; $display("FAIL rand_int_o cyc=%0d got=%b exp=%b", cyc, int_o, |(m_int & m_inten)); end
      checks++; if ({4'h0, nf_ceb} !== m_ce || {nf_mode, nf_ecc_en} !== {m_mode[5:4], m_mode[0]}) begin
        failures++; $display("FAIL rand_ce_mode cyc=%0d got=%h/%h/%b exp=%h/%h", cyc, nf_ceb, nf_mode, nf_ecc_en, m_ce, m_mode); end
      checks++; if ({nf_edo_en, nf_total_cycle, nf_high_cycle} !== m_timing) begin
        failures++; $display("FAIL rand_timing cyc=%0d got=%h exp=%h", cyc, {nf_edo_en, nf_total_cycle, nf_high_cycle}, m_timing); end
      checks++; if (nf_row_addr !== {m_row[3], m_row[2], m_row[1], m_row[0]} || nf_rand_seed !== {m_seed[3], m_seed[2], m_seed[1], m_seed[0]}) begin
        failures++; $display("FAIL rand_row_seed cyc=%0d got=%h/%h", cyc, nf_row_addr, nf_rand_seed); end
    end
    reg_wr = 1'b0; reg_rd = 1'b0; cmd_ready = 1'b0; done_i = 1'b0; err_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fifo_ovf();
    test_full_pushpop();
    test_rnb();
    test_row_seed();
`ifdef NFC_SFR_CMD_FLUSH_EN
    test_flush();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
